audio_i2s_tx: RTL and testbench
===============================

# audio_i2s_tx

Stereo I2S transmitter for the audio codec on the Arduino header. It generates the codec master clock (MCLK), bit clock (BCLK), word select (LRCLK) and serial data from a single 50 MHz system clock. 16-bit stereo sample pairs arrive through a small valid/ready FIFO fed by the SoC audio path, and each pair is serialised in I2S format. This block replaces the free-running MCLK counter in the top level and drives the codec pins directly.

## Interface
- DEPTH, 4: FIFO depth in stereo pairs; power of 2, ≥2.
- SAMPLE_W, 16: bits per channel sample; ≤ SLOT_W.
- SLOT_W, 32: BCLKs per channel slot; a frame is 2·SLOT_W BCLKs.
- BCLK_DIV, 16: clk cycles per BCLK period; power of 2, ≥4.
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  synchronous reset, active-low.
- en  in  1  run enable; when low, the clock generators and serialiser hold at their reset state.
- in_valid  in  1  sample pair offered.
- in_ready  out  1  FIFO not full.
- in_left  in  SAMPLE_W  left sample, two's complement.
- in_right  in  SAMPLE_W  right sample, two's complement.
- clear_underrun  in  1  clears the sticky underrun flag.
- mclk  out  1  codec MCLK = clk/4.
- bclk  out  1  bit clock = clk/BCLK_DIV.
- lrclk  out  1  word select: 0 = left, 1 = right.
- sdata  out  1  I2S serial data.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- underrun  out  1  sticky; set when a frame starts with the FIFO empty.
- underrun_cnt  out  8  saturating count of underrun frames.

## Operation
- **Divider:** div_cnt counts 0..BCLK_DIV-1 and wraps. It resets to BCLK_DIV-1.
  - bclk = (div_cnt ≥ BCLK_DIV/2).
  - mclk = div_cnt[1].
- **BCLK falling edge:** occurs when div_cnt wraps to 0. bit_cnt (0..2·SLOT_W-1, resets to 2·SLOT_W-1) increments and wraps at each fall.
- **Word select:** lrclk = (bit_cnt ≥ SLOT_W).
- **Frame start:** the fall where bit_cnt becomes 0.
  - If the FIFO is non-empty, pop one pair into the frame register.
  - If the FIFO is empty, load zeros, set underrun, and increment underrun_cnt (saturates at 255).
- **Serial data (I2S, one-BCLK delay):** sdata changes only on a BCLK fall.
  - bit_cnt = k for k in 1..SAMPLE_W: sdata = left[SAMPLE_W-k].
  - bit_cnt = SLOT_W+k for k in 1..SAMPLE_W: sdata = right[SAMPLE_W-k].
  - All other bit_cnt values: sdata = 0.
  - The frame register is consumed MSB-first through a shift register.
- **FIFO:**
  - A push occurs when in_valid && in_ready. in_ready = (level < DEPTH).
  - A push and a pop in the same cycle leave level unchanged. If the FIFO is empty that cycle, the pop counts as an underrun and the pushed pair is stored.
  - Writes beyond full cannot occur because in_ready is low.
- **en low:**
  - div_cnt and bit_cnt are forced to their reset values, and sdata = 0.
  - The FIFO keeps accepting pushes and no pops occur.
  - On the first cycle with en=1, div_cnt wraps to 0, causing an immediate frame start (pop or underrun).
- **clear_underrun:** clears underrun only; underrun_cnt is unaffected. If an underrun event coincides with clear_underrun, the flag ends up set.
- **Reset:** empties the FIFO and clears underrun, underrun_cnt and all state. Reset mid-frame aborts the frame with no glitch requirement on the codec pins.

## Timing
- All outputs are derived from registers with no combinational input-to-output path. in_ready depends only on level.
- Reset values:
  - mclk=1, bclk=1, lrclk=1, sdata=0.
  - in_ready=1, level=0, underrun=0, underrun_cnt=0.
- Defaults give mclk 12.5 MHz, bclk 3.125 MHz, and fs = 48.828 kHz (MCLK = 256·fs).
- Push to level update: 1 cycle.
- Pop occurs on the cycle div_cnt becomes 0 with bit_cnt becoming 0.
  - Left MSB is driven BCLK_DIV cycles later.
  - lrclk falls on the frame-start cycle itself.
- The codec samples sdata on the bclk rising edge, BCLK_DIV/2 cycles after each change.

## Test plan
- **Reset:** hold reset_n=0 for 3 cycles → all outputs at their reset values; mclk stays 1 while en=0.
- **Single pair:** push left=0xA5A5, right=0x5A5A, then raise en → lrclk=0 for 32 BCLKs then 1 for 32 BCLKs. sdata at rising edges reads 0, A5A5 MSB-first, fifteen 0s, then 0, 5A5A MSB-first, fifteen 0s. mclk toggles every 2 clk cycles.
- **Backpressure:** with en=0, push 5 pairs while holding in_valid → in_ready drops after the 4th (level=4). Raise en → level=3 on the first cycle and in_ready=1. The 5th pair is accepted the next cycle, so level returns to 4.
- **Underrun:** en=1 with an empty FIFO for 3 frames → sdata stays 0, underrun=1, underrun_cnt=3. Pulse clear_underrun → underrun=0 and count still 3. Hold empty 300 frames → count = 255.
- **Simultaneous push and frame start:** drive a push on the exact frame-start cycle with an empty FIFO → underrun set, level=1, and that pair is transmitted in the next frame.
- **Reset mid-frame:** assert reset_n=0 at bit_cnt=20 → next cycle shows reset values with the FIFO empty. After release, behaviour matches the single-pair test.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: derives MCLK/BCLK/LRCLK from the system clock and
// serialises 16-bit stereo pairs drawn from a small valid/ready FIFO.
module audio_i2s_tx #(
  parameter int DEPTH    = 4,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SAMPLE_W-1:0]       in_left,
  input  logic [SAMPLE_W-1:0]       in_right,
  input  logic                      clear_underrun,
  output logic                      mclk,
  output logic                      bclk,
  output logic                      lrclk,
  output logic                      sdata,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      underrun,
  output logic [7:0]                underrun_cnt
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int FRAME = 2 * SLOT_W;
  localparam int BIT_W = $clog2(FRAME);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);
  localparam logic [BIT_W:0]   SLOT_V   = (BIT_W+1)'(SLOT_W);
  localparam logic [BIT_W:0]   L_HI     = (BIT_W+1)'(SAMPLE_W);
  localparam logic [BIT_W:0]   R_LO     = (BIT_W+1)'(SLOT_W + 1);
  localparam logic [BIT_W:0]   R_HI     = (BIT_W+1)'(SLOT_W + SAMPLE_W);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_next;
  logic [BIT_W:0]        bit_next_ext;
  logic                  fall;
  logic                  frame_start;
  logic                  data_win;
  logic                  push;
  logic                  pop;
  logic                  underrun_evt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [2*SAMPLE_W-1:0] shift_reg;
  logic [2*SAMPLE_W-1:0] mem [DEPTH];

  assign fall         = en && (div_cnt == DIV_LAST);
  assign bit_next     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
  assign bit_next_ext = {1'b0, bit_next};
  assign frame_start  = fall && (bit_cnt == BIT_LAST);
  assign data_win     = ((bit_next_ext >= (BIT_W+1)'(1)) && (bit_next_ext <= L_HI)) ||
                        ((bit_next_ext >= R_LO) && (bit_next_ext <= R_HI));

  assign push         = in_valid && in_ready;
  assign pop          = frame_start && (level != '0);
  assign underrun_evt = frame_start && (level == '0);

  assign in_ready = (level < LVL_FULL);
  assign mclk     = div_cnt[1];
  assign bclk     = div_cnt[DIV_W-1];
  assign lrclk    = ({1'b0, bit_cnt} >= SLOT_V);

  // Clock generators park at their last count so enabling wraps straight into a frame start
  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      div_cnt <= DIV_LAST;
      bit_cnt <= BIT_LAST;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      if (fall) bit_cnt <= bit_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_reg <= '0;
      sdata     <= 1'b0;
    end else if (!en) begin
      sdata <= 1'b0;
    end else if (fall) begin
      if (frame_start) begin
        shift_reg <= pop ? mem[rd_ptr] : '0;
        sdata     <= 1'b0;
      end else if (data_win) begin
        sdata     <= shift_reg[2*SAMPLE_W-1];
        shift_reg <= {shift_reg[2*SAMPLE_W-2:0], 1'b0};
      end else begin
        sdata <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_left, in_right};
  end

  // A push into an empty FIFO during an underrun frame start still raises level
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      if (underrun_evt)        underrun <= 1'b1;
      else if (clear_underrun) underrun <= 1'b0;
      if (underrun_evt && (underrun_cnt != 8'hFF)) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench for audio_i2s_tx: stimulus queues expected frames, a monitor
// reassembles each frame from sdata at bclk rising edges and compares.
module tb_audio_i2s_tx;

  localparam int DEPTH      = 4;
  localparam int SAMPLE_W   = 16;
  localparam int SLOT_W     = 20;
  localparam int BCLK_DIV   = 4;
  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int FRAME_CYC  = FRAME_BITS * BCLK_DIV;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } pair_t;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                en = 1'b0;
  logic                in_valid = 1'b0;
  logic                clear_underrun = 1'b0;
  logic [SAMPLE_W-1:0] in_left = '0;
  logic [SAMPLE_W-1:0] in_right = '0;
  logic                in_ready, mclk, bclk, lrclk, sdata, underrun;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]          underrun_cnt;

  int    total = 0;
  int    bad = 0;
  pair_t sb[$];

  audio_i2s_tx #(
    .DEPTH(DEPTH), .SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .clear_underrun(clear_underrun),
    .mclk(mclk), .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .level(level),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r,
                               input bit expect_tx);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (expect_tx) sb.push_back('{l: l, r: r});
  endtask

  task automatic expectSilence(input int frames);
    for (int i = 0; i < frames; i++) sb.push_back('{l: '0, r: '0});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_mclk"}, 64'(mclk), 64'd1);
    checkOutput({tag, "_bclk"}, 64'(bclk), 64'd1);
    checkOutput({tag, "_lrclk"}, 64'(lrclk), 64'd1);
    checkOutput({tag, "_sdata"}, 64'(sdata), 64'd0);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_level"}, 64'(level), 64'd0);
    checkOutput({tag, "_underrun"}, 64'(underrun), 64'd0);
    checkOutput({tag, "_underrun_cnt"}, 64'(underrun_cnt), 64'd0);
  endtask

  // en stays high for exactly whole frames so no extra frame start is triggered
  task automatic runEn(input int frames);
    en = 1'b1;
    for (int i = 0; i < frames * FRAME_CYC; i++) begin
      @(negedge clk);
      if (i < 8) checkOutput("mclk_phase", 64'(mclk), 64'((i % 4) >= 2));
    end
    en = 1'b0;
  endtask

  task automatic pulseClear();
    clear_underrun = 1'b1;
    @(negedge clk);
    clear_underrun = 1'b0;
  endtask

  task automatic checkFrame(input logic [FRAME_BITS-1:0] bits, input logic [FRAME_BITS-1:0] lrs);
    pair_t               exp;
    logic [SAMPLE_W-1:0] act_l, act_r;
    logic [FRAME_BITS-1:0] exp_lr;
    logic                stray;
    act_l = '0;
    act_r = '0;
    stray = 1'b0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      exp_lr[i] = (i >= SLOT_W);
      if (i >= 1 && i <= SAMPLE_W)                       act_l[SAMPLE_W-i] = bits[i];
      else if (i >= SLOT_W + 1 && i <= SLOT_W + SAMPLE_W) act_r[SAMPLE_W-(i-SLOT_W)] = bits[i];
      else                                                stray = stray | bits[i];
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL frame_unexpected: got l=%0h r=%0h expected no frame", act_l, act_r);
    end else begin
      exp = sb.pop_front();
      checkOutput("frame_data", 64'({act_l, act_r, stray}), 64'({exp.l, exp.r, 1'b0}));
      checkOutput("frame_lrclk", 64'(lrs), 64'(exp_lr));
    end
  endtask

  // Monitor: sample just after each clk edge, capture sdata/lrclk on bclk rises
  initial begin
    logic prev_b, prev_lr, in_frame;
    int   idx;
    logic [FRAME_BITS-1:0] bits, lrs;
    prev_b = 1'b1;
    prev_lr = 1'b1;
    in_frame = 1'b0;
    idx = 0;
    bits = '0;
    lrs = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || !en) begin
        prev_b = 1'b1;
        prev_lr = 1'b1;
        in_frame = 1'b0;
      end else begin
        if (!prev_b && bclk) begin
          if (!lrclk && prev_lr) begin
            in_frame = 1'b1;
            idx = 0;
          end
          if (in_frame) begin
            bits[idx] = sdata;
            lrs[idx] = lrclk;
            idx++;
            if (idx == FRAME_BITS) begin
              in_frame = 1'b0;
              checkFrame(bits, lrs);
            end
          end
          prev_lr = lrclk;
        end
        prev_b = bclk;
      end
    end
  end

  initial begin
    // Reset and idle clocks
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("idle_mclk", 64'(mclk), 64'd1);
    end

    // Single pair
    applyStimulus(16'hA5A5, 16'h5A5A, 1'b1);
    checkOutput("single_level", 64'(level), 64'd1);
    runEn(1);
    checkOutput("single_level_after", 64'(level), 64'd0);
    checkOutput("single_underrun", 64'(underrun), 64'd0);

    // Backpressure
    applyStimulus(16'h1111, 16'hEEEE, 1'b1);
    applyStimulus(16'h2222, 16'hDDDD, 1'b1);
    applyStimulus(16'h3333, 16'hCCCC, 1'b1);
    applyStimulus(16'h4444, 16'hBBBB, 1'b1);
    in_left  = 16'h8000;
    in_right = 16'h7FFF;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("bp_full_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_full_level", 64'(level), 64'd4);
    sb.push_back('{l: 16'h8000, r: 16'h7FFF});
    en = 1'b1;
    @(negedge clk);
    checkOutput("bp_pop_level", 64'(level), 64'd3);
    checkOutput("bp_pop_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    checkOutput("bp_refill_level", 64'(level), 64'd4);
    in_valid = 1'b0;
    repeat (5 * FRAME_CYC - 2) @(negedge clk);
    en = 1'b0;
    checkOutput("bp_drained", 64'(level), 64'd0);
    checkOutput("bp_underrun", 64'(underrun), 64'd0);

    // Underrun and saturation
    expectSilence(3);
    runEn(3);
    checkOutput("ur_flag", 64'(underrun), 64'd1);
    checkOutput("ur_cnt3", 64'(underrun_cnt), 64'd3);
    pulseClear();
    checkOutput("ur_cleared", 64'(underrun), 64'd0);
    checkOutput("ur_cnt_kept", 64'(underrun_cnt), 64'd3);
    expectSilence(260);
    runEn(260);
    checkOutput("ur_cnt_sat", 64'(underrun_cnt), 64'd255);
    checkOutput("ur_flag_sat", 64'(underrun), 64'd1);

    // Push coinciding with an empty-FIFO frame start
    pulseClear();
    checkOutput("sim_pre_flag", 64'(underrun), 64'd0);
    in_left  = 16'h8001;
    in_right = 16'h7FFE;
    in_valid = 1'b1;
    en = 1'b1;
    expectSilence(1);
    sb.push_back('{l: 16'h8001, r: 16'h7FFE});
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("sim_level", 64'(level), 64'd1);
    checkOutput("sim_flag", 64'(underrun), 64'd1);
    checkOutput("sim_cnt", 64'(underrun_cnt), 64'd255);
    repeat (2 * FRAME_CYC - 1) @(negedge clk);
    en = 1'b0;
    checkOutput("sim_drained", 64'(level), 64'd0);

    // Reset mid-frame: frame aborted, FIFO emptied
    applyStimulus(16'h1357, 16'hFEDC, 1'b0);
    applyStimulus(16'h2468, 16'hBA98, 1'b0);
    en = 1'b1;
    repeat (80) @(negedge clk);
    checkOutput("mid_lrclk_bit19", 64'(lrclk), 64'd0);
    @(negedge clk);
    checkOutput("mid_lrclk_bit20", 64'(lrclk), 64'd1);
    checkOutput("mid_level", 64'(level), 64'd1);
    reset_n = 1'b0;
    en = 1'b0;
    @(negedge clk);
    checkResetState("midreset");
    reset_n = 1'b1;
    applyStimulus(16'hA5A5, 16'h5A5A, 1'b1);
    runEn(1);
    checkOutput("post_reset_underrun", 64'(underrun), 64'd0);
    checkOutput("post_reset_level", 64'(level), 64'd0);

    repeat (4) @(negedge clk);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
